// File: rtl/mdu.sv
// Multiply/divide unit holding the HI/LO pair: multi-cycle mult/multu/div/divu,
// single-cycle mthi/mtlo and combinational mfhi/mflo. madd/msub exist only with MDU_MADD_EN.
//
// state | meaning
// IDLE  | accepts start and mthi/mtlo; busy=0
// BUSY  | counting down the latency of the latched op; busy=1
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MSUB  = 4'b1010;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_div;
    logic        is_multi;
    logic [63:0] res;
    logic        res_we;

    // Launch decode
    always_comb begin
        is_div   = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
        is_multi = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) || is_div;
`ifdef MDU_MADD_EN
        is_multi = is_multi || (MDUOp == OP_MADD) || (MDUOp == OP_MSUB);
`endif
    end

    // Multiplier: the low 64 bits of a 64x64 product of sign-extended operands
    // equal the signed 32x32 product.
    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    assign a_sx   = {{32{a_q[31]}}, a_q};
    assign b_sx   = {{32{b_q[31]}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Divider: one unsigned core shared by div/divu; signed div works on magnitudes
    // so that 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    logic        sdiv;
    logic [31:0] abs_a, abs_b, div_a, div_b, uq, ur, sq, sr;
    assign sdiv  = (op_q == OP_DIV);
    assign abs_a = a_q[31] ? -a_q : a_q;
    assign abs_b = b_q[31] ? -b_q : b_q;
    assign div_a = sdiv ? abs_a : a_q;
    assign div_b = sdiv ? abs_b : b_q;
    assign uq    = (div_b == 32'd0) ? 32'd0 : div_a / div_b;
    assign ur    = (div_b == 32'd0) ? 32'd0 : div_a % div_b;
    assign sq    = (a_q[31] ^ b_q[31]) ? -uq : uq;
    assign sr    = a_q[31] ? -ur : ur;

    always_comb begin
        res    = 64'd0;
        res_we = 1'b0;
        case (op_q)
            OP_MULT: begin
                res    = prod_s;
                res_we = 1'b1;
            end
            OP_MULTU: begin
                res    = prod_u;
                res_we = 1'b1;
            end
            OP_DIV: begin
                res    = {sr, sq};
                res_we = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res    = {ur, uq};
                res_we = (b_q != 32'd0);
            end
`ifdef MDU_MADD_EN
            // HI/LO cannot change while busy, so the current pair is the start-edge base.
            OP_MADD: begin
                res    = {hi_q, lo_q} + prod_s;
                res_we = 1'b1;
            end
            OP_MSUB: begin
                res    = {hi_q, lo_q} - prod_s;
                res_we = 1'b1;
            end
`endif
            default: begin
                res    = 64'd0;
                res_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start && is_multi) begin
                    state_d = BUSY;
                    op_d    = MDUOp;
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
                end
                if (MDUOp == OP_MTHI) begin
                    hi_d = A;
                end
                if (MDUOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (res_we) begin
                        {hi_d, lo_d} = res;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;
    assign out  = (MDUOp == OP_MFHI) ? hi_q :
                  (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO/busy/out values checked with immediate assertions.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [3:0]  MDUOp;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] out;

    int compared;
    int mismatched;
    int ncyc;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .MDUOp (MDUOp),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MDUOp = 4'd0;
        start = 1'b0;
    endtask

    // Launches an op, scrambles the operands after the start edge, and returns
    // the number of cycles busy stayed high (bounded).
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cycles);
        MDUOp = op;
        start = 1'b1;
        A     = a;
        B     = b;
        #1;
        check({tag, "_busy_at_start"}, {31'd0, busy}, 32'd0);
        step();
        idle_inputs();
        A = 32'hA5A5_5A5A;
        B = 32'h0000_0003;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset = 1'b0;
        MDUOp = 4'd0;
        start = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        step();
        step();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b1;

        MDUOp = 4'b0111;
        A     = 32'h1234_5678;
        step();
        idle_inputs();
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_lo", LO, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);

        MDUOp = 4'b0101;
        #1;
        check("mfhi_out", out, 32'h1234_5678);
        MDUOp = 4'b0110;
        #1;
        check("mflo_out", out, 32'd0);
        MDUOp = 4'b0000;
        #1;
        check("none_out", out, 32'd0);
        step();
        check("mfhi_no_write", HI, 32'h1234_5678);

        run_op("mult", 4'b0001, 32'hFFFF_FFFF, 32'h0000_0002, ncyc);
        check("mult_cycles", ncyc, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);

        run_op("multu", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, ncyc);
        check("multu_cycles", ncyc, 32'd5);
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        run_op("div", 4'b0011, 32'hFFFF_FFF9, 32'h0000_0002, ncyc);
        check("div_cycles", ncyc, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        run_op("divu0", 4'b0100, 32'h0000_0007, 32'h0000_0000, ncyc);
        check("divu0_cycles", ncyc, 32'd10);
        check("divu0_hi", HI, 32'hFFFF_FFFF);
        check("divu0_lo", LO, 32'hFFFF_FFFD);

        run_op("div_ovf", 4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, ncyc);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'h0000_0000);

        run_op("div_neg_b", 4'b0011, 32'h0000_0007, 32'hFFFF_FFFE, ncyc);
        check("div_neg_b_lo", LO, 32'hFFFF_FFFD);
        check("div_neg_b_hi", HI, 32'h0000_0001);

        run_op("divu", 4'b0100, 32'hFFFF_FFFF, 32'h0000_000A, ncyc);
        check("divu_lo", LO, 32'h1999_9999);
        check("divu_hi", HI, 32'h0000_0005);

        // mult with a div start in busy cycle 2 and an mtlo in busy cycle 3
        MDUOp = 4'b0001;
        start = 1'b1;
        A     = 32'd3;
        B     = 32'd4;
        step();
        idle_inputs();
        ncyc = 0;
        while (busy && ncyc < 100) begin
            ncyc++;
            idle_inputs();
            if (ncyc == 2) begin
                MDUOp = 4'b0011;
                start = 1'b1;
                A     = 32'd100;
                B     = 32'd7;
            end else if (ncyc == 3) begin
                MDUOp = 4'b1000;
                A     = 32'd5;
            end
            step();
        end
        idle_inputs();
        check("hazard_cycles", ncyc, 32'd5);
        check("hazard_hi", HI, 32'd0);
        check("hazard_lo", LO, 32'd12);
        step();
        check("hazard_no_div", {31'd0, busy}, 32'd0);

        // start with a non-multi-cycle op
        MDUOp = 4'b0101;
        start = 1'b1;
        step();
        idle_inputs();
        check("start_mfhi_busy", {31'd0, busy}, 32'd0);

        // reset aborting a mult in busy cycle 3
        MDUOp = 4'b0111;
        A     = 32'h0000_DEAD;
        step();
        MDUOp = 4'b0001;
        start = 1'b1;
        A     = 32'd5;
        B     = 32'd6;
        step();
        idle_inputs();
        step();
        step();
        check("abort_busy_c3", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("abort_no_late_lo", LO, 32'd0);
        check("abort_no_late_busy", {31'd0, busy}, 32'd0);

        // start coincident with reset
        reset = 1'b0;
        MDUOp = 4'b0001;
        start = 1'b1;
        A     = 32'd3;
        B     = 32'd3;
        step();
        reset = 1'b1;
        idle_inputs();
        check("start_in_reset_busy", {31'd0, busy}, 32'd0);
        step();
        check("start_in_reset_lo", LO, 32'd0);

        // accumulate
        MDUOp = 4'b0111;
        A     = 32'd0;
        step();
        MDUOp = 4'b1000;
        A     = 32'hFFFF_FFFF;
        step();
        idle_inputs();
`ifdef MDU_MADD_EN
        run_op("madd", 4'b1001, 32'd1, 32'd1, ncyc);
        check("madd_cycles", ncyc, 32'd5);
        check("madd_hi", HI, 32'd1);
        check("madd_lo", LO, 32'd0);
        run_op("msub", 4'b1010, 32'd1, 32'd1, ncyc);
        check("msub_hi", HI, 32'd0);
        check("msub_lo", LO, 32'hFFFF_FFFF);
`else
        MDUOp = 4'b1001;
        start = 1'b1;
        A     = 32'd1;
        B     = 32'd1;
        step();
        idle_inputs();
        check("madd_off_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("madd_off_hi", HI, 32'd0);
        check("madd_off_lo", LO, 32'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
